// File: rtl/axis_stream_source.sv
// AXI-Stream frame generator: counting data, tlast on the final beat, LFSR-throttled gaps.
// Latency: first beat is presented one cycle after an accepted start. All outputs are registered.
// Backpressure: a presented beat and its tlast hold until m_tready; m_tvalid never looks at m_tready combinationally.
module axis_stream_source #(
    parameter int          DATA_WIDTH = 8,
    parameter int          LEN_WIDTH  = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [DATA_WIDTH-1:0] cfg_first,
    input  logic [DATA_WIDTH-1:0] cfg_step,
    input  logic [1:0]            cfg_throttle,
    output logic                  m_tvalid,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  sent_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);
    localparam logic [15:0]          LFSR_TAPS = 16'hB400;

    state_t                state_q, state_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  idx_q, idx_d;
    logic [LEN_WIDTH-1:0]  sent_q, sent_d;
    logic [DATA_WIDTH-1:0] step_q, step_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [1:0]            thr_q, thr_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  hs;
    logic                  final_hs;
    logic                  slot_free;
    logic [LEN_WIDTH-1:0]  nxt_idx;
    logic [DATA_WIDTH-1:0] nxt_acc;

    // Galois form: shift right, fold the taps back in when a one falls out.
    assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);

    assign hs        = tvalid_q & m_tready;
    assign final_hs  = hs & (idx_q == (len_q - LEN_ONE));
    assign slot_free = ~tvalid_q | hs;
    // idx/acc always describe the beat currently pending or next to be presented.
    assign nxt_idx   = hs ? (idx_q + LEN_ONE) : idx_q;
    assign nxt_acc   = hs ? (acc_q + step_q) : acc_q;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        step_d   = step_q;
        thr_d    = thr_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        sent_d   = sent_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                if (start) begin
                    sent_d = '0;
                    if (cfg_len == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = ST_RUN;
                        len_d    = cfg_len;
                        step_d   = cfg_step;
                        thr_d    = cfg_throttle;
                        idx_d    = '0;
                        acc_d    = cfg_first;
                        tvalid_d = (lfsr_q[1:0] >= cfg_throttle);
                        if (lfsr_q[1:0] >= cfg_throttle) begin
                            tdata_d = cfg_first;
                            tlast_d = (cfg_len == LEN_ONE);
                        end
                    end
                end
            end

            ST_RUN: begin
                if (hs) begin
                    sent_d = (sent_q == len_q) ? sent_q : (sent_q + LEN_ONE);
                end
                if (final_hs) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                end else if (slot_free) begin
                    idx_d    = nxt_idx;
                    acc_d    = nxt_acc;
                    tvalid_d = (lfsr_q[1:0] >= thr_q);
                    if (lfsr_q[1:0] >= thr_q) begin
                        tdata_d = nxt_acc;
                        tlast_d = (nxt_idx == (len_q - LEN_ONE));
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d  = ST_IDLE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            lfsr_q   <= LFSR_SEED;
            len_q    <= '0;
            step_q   <= '0;
            thr_q    <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            sent_q   <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            len_q    <= len_d;
            step_q   <= step_d;
            thr_q    <= thr_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            sent_q   <= sent_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign m_tvalid   = tvalid_q;
    assign m_tdata    = tdata_q;
    assign m_tlast    = tlast_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sent_count = sent_q;

endmodule

// File: doc/axis_stream_source.md
# axis_stream_source

Synthesizable AXI-Stream transmitter that generates a programmable, optionally throttled data stream into the slave (`s_*`) port of `axi_stream_fifo`. It lets the FIFO be exercised on-chip and in system simulation without a file-driven bench. A frame is a counting sequence with `tlast` on the final beat. Gaps are inserted by an LFSR under a configurable rate.

## Interface
- `DATA_WIDTH`, 8: width of `m_tdata`.
- `LEN_WIDTH`, 16: width of the beat count and `sent_count`.
- `LFSR_SEED`, 16'hACE1: reset value of the 16-bit throttle LFSR; must be nonzero.

Ports (name, direction, width, meaning):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-low (asserted when 0).
- `start`  in  1  begin a frame; sampled only in IDLE.
- `cfg_len`  in  LEN_WIDTH  beats in the frame; 0 means an empty frame.
- `cfg_first`  in  DATA_WIDTH  data value of beat 0.
- `cfg_step`  in  DATA_WIDTH  increment between beats.
- `cfg_throttle`  in  2  gap rate, 0 (none) to 3 (heaviest).
- `m_tvalid`  out  1  beat valid.
- `m_tdata`  out  DATA_WIDTH  beat data.
- `m_tlast`  out  1  final beat of the frame.
- `m_tready`  in  1  sink ready.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse at frame end.
- `sent_count`  out  LEN_WIDTH  handshakes completed in the current or last frame.

## Operation
- FSM states and transitions:
  - IDLE → RUN when `start`=1 and `cfg_len`≠0. `cfg_*` are latched, `sent_count` is cleared, and the beat index is set to 0.
  - IDLE → DONE when `start`=1 and `cfg_len`=0. `sent_count` is cleared.
  - RUN → DONE on the handshake of the beat with index `cfg_len`−1.
  - DONE → IDLE unconditionally after one cycle.
- `start` in RUN or DONE is ignored. `cfg_*` changes after latching have no effect on the frame in progress.
- Data: beat k carries `cfg_first + k*cfg_step` mod 2^DATA_WIDTH, implemented as a running accumulator. Wrap-around is silent.
- `m_tlast` = 1 exactly on beat `cfg_len`−1. For `cfg_len`=1, beat 0 carries `tlast`.
- Handshake: a beat transfers on a rising edge with `m_tvalid` & `m_tready`. Once `m_tvalid` is high, `m_tvalid`, `m_tdata` and `m_tlast` hold stable until that handshake. `m_tvalid` never depends combinationally on `m_tready`.
- Throttle:
  - The LFSR is Galois with taps 16'hB400. It advances every cycle while `rst`=1.
  - In RUN, when no beat is pending (tvalid low, or handshake this cycle), the next cycle presents a beat unless `lfsr[1:0] < cfg_throttle`.
  - A gap inserts an idle cycle, then the check repeats.
  - With `cfg_throttle`=0 and `m_tready` held high, one beat transfers per cycle.
- `sent_count` increments on every handshake, saturates at `cfg_len`, and holds after `done` until the next accepted `start`.

## Timing
- Reset (`rst`=0, asynchronous):
  - `m_tvalid`, `m_tlast`, `m_tdata`, `busy`, `done` and `sent_count` are 0; state is IDLE; LFSR = `LFSR_SEED`.
  - Reset mid-frame drops `m_tvalid` immediately, discards the frame, and pulses no `done`.
  - Release is synchronous-safe: there is no activity until the first `start` after deassertion.
- `start` sampled at edge T: `busy` is high from T+1. With `cfg_throttle`=0, `m_tvalid` is high from T+1 (one-cycle latency). For an empty frame, `done`=1 in cycle T+1.
- Last handshake at edge E: `m_tvalid`=0 and `done`=1 in cycle E+1. IDLE from E+2, which is the earliest cycle a new `start` is accepted.
- All outputs are registered.

## Test plan
- Basic frame: `cfg_len`=4, `cfg_first`=0x10, `cfg_step`=1, throttle 0, `m_tready`=1.
  - Beats 10, 11, 12, 13 in 4 consecutive cycles starting T+1.
  - `tlast` only on 0x13.
  - `done` pulses the next cycle; `sent_count`=4.
- Backpressure: same frame, with `m_tready` dropped for 3 cycles while beat 0x11 is valid.
  - `m_tvalid`, `m_tdata`=0x11 and `m_tlast`=0 remain stable.
  - No beat is lost or duplicated; total 4.
- Wrap and throttle: `cfg_len`=16, `cfg_first`=0xF0, `cfg_step`=3, throttle 3, random `m_tready`.
  - Sequence F0, F3, F6, F9, FC, FF, 02, 05, …, 1D in order.
  - At least one gap cycle with `m_tvalid`=0 mid-frame.
  - `sent_count`=16.
- Empty frame: `start` with `cfg_len`=0.
  - `m_tvalid` never high.
  - `done`=1 in T+1; `sent_count`=0; `busy` low from T+2.
- Ignored start and mid-frame reset: `cfg_len`=8.
  - `start` pulsed again during RUN has no effect.
  - Assert `rst`=0 after 2 handshakes: `m_tvalid`, `busy` and `sent_count` go to 0 immediately, with no `done`.
  - After release, a new `start` produces beat 0 = `cfg_first`.
- End-to-end with `axi_stream_fifo` (depth 16), `cfg_len`=20, FIFO read side stalled.
  - Source stalls with beat index 16 pending and `s_tready` low.
  - When the read side is enabled, all 20 values emerge in order, with `tlast` handled by the bench on the 20th.
